// File: rtl/vga_ram_arb.sv
// Single-port pixel RAM arbiter: display reads win outright, writer traffic is buffered
// in a small FIFO and drained in idle cycles. Optional blocked-write statistics: ARB_CONFLICT_STAT_EN.
module vga_ram_arb #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              vga_clk,
    input  logic              sys_rst,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [15:0]       conflict_cnt
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        G_IDLE,
        G_RD,
        G_WR
    } grant_t;

    grant_t state_reg;
    grant_t state_next;

    logic [ADDR_W-1:0] addr_mem_reg [FIFO_DEPTH];
    logic [DATA_W-1:0] data_mem_reg [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign full     = (count_reg == CNT_W'(FIFO_DEPTH));
    assign empty    = (count_reg == '0);
    // Ready follows the registered count only, so a pop never frees a slot in the same cycle.
    assign wr_ready = ~full & ~sys_rst;
    assign push     = wr_req & wr_ready;

    always_comb begin
        state_next = G_IDLE;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;
        pop        = 1'b0;
        if (!sys_rst) begin
            if (rd_req) begin
                state_next = G_RD;
                ram_en     = 1'b1;
                ram_addr   = rd_addr;
            end else if (!empty) begin
                state_next = G_WR;
                ram_en     = 1'b1;
                ram_we     = 1'b1;
                ram_addr   = addr_mem_reg[rd_ptr_reg];
                ram_wdata  = data_mem_reg[rd_ptr_reg];
                pop        = 1'b1;
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            state_reg  <= G_IDLE;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked entirely by the pointers and count.
    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            always_ff @(posedge vga_clk) begin
                if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    addr_mem_reg[gi] <= wr_addr;
                    data_mem_reg[gi] <= wr_data;
                end
            end
        end
    endgenerate

    // A read grant last cycle means the RAM is presenting that word now.
    assign rd_valid = (state_reg == G_RD);
    assign rd_data  = ram_rdata;

`ifdef ARB_CONFLICT_STAT_EN
    logic [15:0] conflict_reg;

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            conflict_reg <= '0;
        end else if (rd_req && !empty && (conflict_reg != 16'hFFFF)) begin
            conflict_reg <= conflict_reg + 16'd1;
        end
    end

    assign conflict_cnt = conflict_reg;
`else
    assign conflict_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_ram_arb.sv
// Randomized and directed bench for vga_ram_arb against a queue-based transaction model.
module tb_vga_ram_arb;

    localparam int DEPTH = 4;

    logic        vga_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        rd_req = 1'b0;
    logic [15:0] rd_addr = '0;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        wr_req = 1'b0;
    logic [15:0] wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        wr_ready;
    logic        ram_en;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata = '0;
    logic [15:0] conflict_cnt;

    vga_ram_arb #(.ADDR_W(16), .DATA_W(16), .FIFO_DEPTH(DEPTH)) dut (
        .vga_clk(vga_clk), .sys_rst(sys_rst),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .conflict_cnt(conflict_cnt)
    );

    always #5 vga_clk = ~vga_clk;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] d;
    } entry_t;

    // Reference model state
    entry_t      q[$];
    bit          prev_rd = 0;
    int unsigned model_cnt = 0;

    int errors = 0;
    int checks = 0;

    bit          fixed_rdata_en = 0;
    logic [15:0] fixed_rdata = '0;

    // Observations of the last step, for scenario-level checks
    logic        obs_ready, obs_en, obs_we, obs_rd_valid;
    logic [15:0] obs_addr, obs_wdata, obs_rd_data, obs_cnt;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit rd, input logic [15:0] raddr,
                        input bit wr, input logic [15:0] waddr, input logic [15:0] wdata);
        bit exp_ready;
        int grant;   // 0 none, 1 read, 2 write
        @(negedge vga_clk);
        sys_rst   = rst;
        rd_req    = rd;
        rd_addr   = raddr;
        wr_req    = wr;
        wr_addr   = waddr;
        wr_data   = wdata;
        ram_rdata = fixed_rdata_en ? fixed_rdata : 16'($urandom);
        #1;
        exp_ready = !rst && (q.size() < DEPTH);
        grant     = rst ? 0 : (rd ? 1 : ((q.size() != 0) ? 2 : 0));
        check_value("wr_ready", 32'(wr_ready), 32'(exp_ready));
        check_value("ram_en", 32'(ram_en), 32'(grant != 0));
        check_value("ram_we", 32'(ram_we), 32'(grant == 2));
        if (grant == 1) check_value("ram_addr_rd", 32'(ram_addr), 32'(raddr));
        if (grant == 2) begin
            check_value("ram_addr_wr", 32'(ram_addr), 32'(q[0].a));
            check_value("ram_wdata", 32'(ram_wdata), 32'(q[0].d));
        end
        check_value("rd_valid", 32'(rd_valid), 32'(prev_rd));
        if (prev_rd) check_value("rd_data", 32'(rd_data), 32'(ram_rdata));
        check_value("conflict_cnt", 32'(conflict_cnt), 32'(model_cnt));
        obs_ready = wr_ready; obs_en = ram_en; obs_we = ram_we; obs_addr = ram_addr;
        obs_wdata = ram_wdata; obs_rd_valid = rd_valid; obs_rd_data = rd_data; obs_cnt = conflict_cnt;
        @(posedge vga_clk);
        prev_rd = !rst && rd;
`ifdef ARB_CONFLICT_STAT_EN
        if (rst) model_cnt = 0;
        else if (rd && q.size() != 0 && model_cnt < 32'hFFFF) model_cnt++;
`endif
        if (rst) begin
            q.delete();
        end else begin
            if (grant == 2) void'(q.pop_front());
            if (wr && exp_ready) q.push_back('{a: waddr, d: wdata});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 16'h0, 0, 16'h0, 16'h0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int accepted;
        int writes;
        bit fifth_taken;

        // Reset held: ready and strobe must stay low even with requests
        for (int i = 0; i < 3; i++) step(1, 1, 16'h1234, 1, 16'h5678, 16'h9ABC);
        step(0, 0, 16'h0, 0, 16'h0, 16'h0);
        check_value("reset_rd_valid", 32'(obs_rd_valid), 32'd0);
        check_value("reset_wr_ready", 32'(obs_ready), 32'd1);
        check_value("reset_cnt", 32'(obs_cnt), 32'd0);

        // Idle write
        step(0, 0, 16'h0, 1, 16'h0010, 16'hF800);
        step(0, 0, 16'h0, 0, 16'h0, 16'h0);
        check_value("idle_wr_we", 32'(obs_we), 32'd1);
        check_value("idle_wr_addr", 32'(obs_addr), 32'h0010);
        check_value("idle_wr_data", 32'(obs_wdata), 32'hF800);
        step(0, 0, 16'h0, 0, 16'h0, 16'h0);
        check_value("idle_wr_empty", 32'(obs_en), 32'd0);

        // Read burst with five offered writes
        accepted = 0;
        writes   = 0;
        for (int i = 0; i < 640; i++) begin
            step(0, 1, 16'(16'h0400 + i), i < 5, 16'(16'h0200 + i), 16'(16'h1000 + i));
            if (i < 5 && obs_ready) accepted++;
            if (obs_we) writes++;
            if (i == 4) check_value("burst_ready_after4", 32'(obs_ready), 32'd0);
        end
        check_value("burst_accepted", 32'(accepted), 32'd4);
        check_value("burst_ram_writes", 32'(writes), 32'd0);

        // Drain in accept order while the fifth write is re-offered
        fifth_taken = 0;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 16'h0, !fifth_taken, 16'h0204, 16'h1004);
            if (!fifth_taken && obs_ready) fifth_taken = 1;
            check_value("drain_we", 32'(obs_we), 32'd1);
            check_value("drain_addr", 32'(obs_addr), 32'(16'h0200 + i));
        end
        step(0, 0, 16'h0, 0, 16'h0, 16'h0);
        check_value("fifth_accepted", 32'(fifth_taken), 32'd1);
        check_value("fifth_addr", 32'(obs_addr), 32'h0204);
        idle(2);

        // Read latency
        step(0, 1, 16'h0100, 0, 16'h0, 16'h0);
        check_value("lat_addr", 32'(obs_addr), 32'h0100);
        fixed_rdata_en = 1;
        fixed_rdata    = 16'h07E0;
        step(0, 0, 16'h0, 0, 16'h0, 16'h0);
        fixed_rdata_en = 0;
        check_value("lat_valid", 32'(obs_rd_valid), 32'd1);
        check_value("lat_data", 32'(obs_rd_data), 32'h07E0);

        // Mid-operation reset with three buffered entries and a read in flight
        for (int i = 0; i < 3; i++) step(0, 1, 16'h0300, 1, 16'(16'h0700 + i), 16'(16'hAA00 + i));
        step(1, 1, 16'h0300, 1, 16'h0777, 16'h7777);
        step(0, 0, 16'h0, 0, 16'h0, 16'h0);
        check_value("mid_rst_en", 32'(obs_en), 32'd0);
        check_value("mid_rst_valid", 32'(obs_rd_valid), 32'd0);
        check_value("mid_rst_cnt", 32'(obs_cnt), 32'd0);
        check_value("mid_rst_ready", 32'(obs_ready), 32'd1);

        // Random traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(99) == 0, $urandom_range(1) == 1, 16'($urandom),
                 $urandom_range(9) < 6, 16'($urandom), 16'($urandom));
        end

        // Conflict counter saturation
        step(1, 0, 16'h0, 0, 16'h0, 16'h0);
        step(0, 1, 16'h0050, 1, 16'h0060, 16'h0070);
        for (int i = 0; i < 70000; i++) step(0, 1, 16'(i), 0, 16'h0, 16'h0);
`ifdef ARB_CONFLICT_STAT_EN
        check_value("cnt_saturated", 32'(obs_cnt), 32'hFFFF);
`else
        check_value("cnt_tied_zero", 32'(obs_cnt), 32'h0000);
`endif
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
